// File: rtl/uart_latch_loader.sv
// rtl/uart_latch_loader.sv - UART 8N1 receiver decoding A/B operand nibbles into latch save strobes
module uart_latch_loader #(
    parameter int          CLKS_PER_BIT = 1042,
    parameter logic [3:0]  CMD_A        = 4'hA,
    parameter logic [3:0]  CMD_B        = 4'hB
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic [3:0]  data_out,
    output logic        save_a_n,
    output logic        save_b_n,
    output logic [7:0]  rx_byte,
    output logic        busy,
    output logic        frame_err,
    output logic        cmd_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_APPLY,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            bit_tick;
    logic            half_tick;

    assign bit_tick  = (cnt == LAST);
    assign half_tick = (cnt == HALF);
    assign busy      = (state != S_IDLE);

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start validation at mid-bit, 8 data bits, stop check
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!rxs) next_state = S_START;
            S_START: if (half_tick) next_state = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (bit_tick && idx == 3'd7) next_state = S_STOP;
            S_STOP:  if (bit_tick) next_state = rxs ? S_APPLY : S_BREAK;
            S_APPLY: next_state = S_IDLE;
            S_BREAK: if (rxs) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Bit timer restarts on every state change so each phase measures from its own entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == S_IDLE || state != next_state || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data bit capture, LSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= 3'd0;
            shreg <= 8'h00;
        end else if (state == S_START) begin
            idx <= 3'd0;
        end else if (state == S_DATA && bit_tick) begin
            shreg[idx] <= rxs;
            idx        <= idx + 1'b1;
        end
    end

    // Registered outputs: strobes and error pulses are asserted on the edge entering APPLY/BREAK
    // and drop on the next edge, so data_out is already stable for the whole low strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= 4'h0;
            save_a_n  <= 1'b1;
            save_b_n  <= 1'b1;
            rx_byte   <= 8'h00;
            frame_err <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            save_a_n  <= 1'b1;
            save_b_n  <= 1'b1;
            frame_err <= 1'b0;
            cmd_err   <= 1'b0;
            if (state == S_STOP && bit_tick) begin
                if (rxs) begin
                    rx_byte <= shreg;
                    if (shreg[7:4] == CMD_A) begin
                        data_out <= shreg[3:0];
                        save_a_n <= 1'b0;
                    end else if (shreg[7:4] == CMD_B) begin
                        data_out <= shreg[3:0];
                        save_b_n <= 1'b0;
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_latch_loader.sv
// tb/tb_uart_latch_loader.sv - scoreboard bench for uart_latch_loader
`timescale 1ns/1ps
module tb_uart_latch_loader;

    localparam int C = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx;
    logic [3:0]  data_out;
    logic        save_a_n;
    logic        save_b_n;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        frame_err;
    logic        cmd_err;

    typedef struct {
        int          kind;   // 0 save_a, 1 save_b, 2 cmd_err, 3 frame_err
        logic [3:0]  d;
        logic [7:0]  b;
        bit          lat;
        time         t_fall;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    uart_latch_loader #(.CLKS_PER_BIT(C), .CMD_A(4'hA), .CMD_B(4'hB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .data_out  (data_out),
        .save_a_n  (save_a_n),
        .save_b_n  (save_b_n),
        .rx_byte   (rx_byte),
        .busy      (busy),
        .frame_err (frame_err),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] d, input logic [7:0] b, input bit lat);
        exp_t e;
        e.kind = kind; e.d = d; e.b = b; e.lat = lat; e.t_fall = $time;
        q.push_back(e);
    endtask

    // Drives nbits of the 10-bit frame starting now; rx keeps the last driven level
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = fr[i];
            repeat (C) @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        bit   prev_active = 0;
        int   kind;
        int   nact;
        int   lat;
        exp_t e;
        forever begin
            @(negedge clk);
            nact = int'(!save_a_n) + int'(!save_b_n) + int'(cmd_err) + int'(frame_err);
            if (nact != 0) begin
                kind = !save_a_n ? 0 : (!save_b_n ? 1 : (cmd_err ? 2 : 3));
                chk("exclusive_events", 8'(nact), 8'd1);
                chk("pulse_width_prev", {7'd0, prev_active}, 8'd0);
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", 8'(kind), 8'(e.kind));
                    chk("data_out", {4'd0, data_out}, {4'd0, e.d});
                    chk("rx_byte", rx_byte, e.b);
                    if (e.lat) begin
                        lat = int'(($time - 5 - e.t_fall) / 10);
                        n_cmp++;
                        if (lat < 154 || lat > 156) begin
                            n_fail++;
                            $display("FAIL latency: got %0d expected 155+/-1", lat);
                        end
                    end
                end
            end
            prev_active = (nact != 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", {4'd0, data_out}, 8'h00);
        chk("rst_save_a_n", {7'd0, save_a_n}, 8'h01);
        chk("rst_save_b_n", {7'd0, save_b_n}, 8'h01);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_errs", {6'd0, frame_err, cmd_err}, 8'h00);
        reset_n = 1'b1;
        fork
            monitor();
        join_none
        repeat (5) @(posedge clk);
        #1;

        // 0xA5: operand A = 5, latency checked
        push(0, 4'h5, 8'hA5, 1'b1);
        send_byte(8'hA5, 1'b1, 10);
        repeat (5) @(posedge clk);
        #1;

        // 0xB3 then 0xA9 with no idle gap
        push(1, 4'h3, 8'hB3, 1'b0);
        send_byte(8'hB3, 1'b1, 10);
        push(0, 4'h9, 8'hA9, 1'b0);
        send_byte(8'hA9, 1'b1, 10);
        repeat (5) @(posedge clk);
        #1;

        // 0x37: bad command, data_out keeps 9
        push(2, 4'h9, 8'h37, 1'b0);
        send_byte(8'h37, 1'b1, 10);
        repeat (5) @(posedge clk);
        #1;

        // 0xA1 with low stop bit, rx stays low: single frame error, stays busy
        push(3, 4'h9, 8'h37, 1'b0);
        send_byte(8'hA1, 1'b0, 10);
        repeat (40) @(posedge clk);
        #1;
        chk("break_busy", {7'd0, busy}, 8'h01);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("break_exit_busy", {7'd0, busy}, 8'h00);

        push(1, 4'h2, 8'hB2, 1'b0);
        send_byte(8'hB2, 1'b1, 10);
        repeat (5) @(posedge clk);
        #1;

        // 4-cycle glitch: start rejected silently
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_busy_in_start", {7'd0, busy}, 8'h01);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_back_idle", {7'd0, busy}, 8'h00);

        // Reset during DATA of 0xA7
        send_byte(8'hA7, 1'b1, 4);
        chk("pre_reset_busy", {7'd0, busy}, 8'h01);
        reset_n = 1'b0;
        rx      = 1'b1;
        #1;
        chk("mid_rst_busy", {7'd0, busy}, 8'h00);
        chk("mid_rst_data_out", {4'd0, data_out}, 8'h00);
        chk("mid_rst_rx_byte", rx_byte, 8'h00);
        chk("mid_rst_strobes", {6'd0, save_a_n, save_b_n}, 8'h03);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(0, 4'h7, 8'hA7, 1'b0);
        send_byte(8'hA7, 1'b1, 10);
        repeat (20) @(posedge clk);
        #1;

        chk("scoreboard_drained", 8'(q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
